// File: rtl/fcmp_unit.sv
// fcmp_unit: pipelined binary32 compare/select (feq/flt/fle/fmin/fmax), 2-cycle latency, valid/ready both sides.
// Ports: clk, rst (sync, active-high); request in_valid/in_ready, op, x, y, tag; flush;
// result out_valid/out_ready, z, out_tag. Optional NaN handling: define FCMP_NAN_EN.
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [31:0]      x,
    input  logic [31:0]      y,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      z,
    output logic [TAG_W-1:0] out_tag
);
    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic [31:0]      s1_x_q, s1_x_d, s1_y_q, s1_y_d, z_q, z_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d, tag_q, tag_d;
    logic             s1_xz_q, s1_xz_d, s1_yz_q, s1_yz_d;
`ifdef FCMP_NAN_EN
    logic             s1_xn_q, s1_xn_d, s1_yn_q, s1_yn_d;
`endif
    logic             s2_en, acc, xs, ys, eq, lt, split, nan_any;
    logic [30:0]      xm, ym;
    logic [31:0]      mn, mx, nan_sel, res;

    // Subnormals are flushed: a zero exponent makes the operand a signless zero.
    always_comb begin
        xs    = s1_x_q[31] & !s1_xz_q;
        ys    = s1_y_q[31] & !s1_yz_q;
        xm    = s1_xz_q ? 31'h0 : s1_x_q[30:0];
        ym    = s1_yz_q ? 31'h0 : s1_y_q[30:0];
        eq    = (xs == ys) & (xm == ym);
        lt    = (xs & !ys) | (!xs & !ys & (xm < ym)) | (xs & ys & (xm > ym));
        // -0 vs +0 compare equal but min/max still pick by sign bit
        split = s1_xz_q & s1_yz_q & (s1_x_q[31] ^ s1_y_q[31]);
        mn    = split ? (s1_x_q[31] ? s1_x_q : s1_y_q) : (lt | eq) ? s1_x_q : s1_y_q;
        mx    = split ? (s1_x_q[31] ? s1_y_q : s1_x_q) : lt ? s1_y_q : s1_x_q;
`ifdef FCMP_NAN_EN
        nan_any = s1_xn_q | s1_yn_q;
        nan_sel = (s1_xn_q & s1_yn_q) ? 32'h7fc00000 : s1_xn_q ? s1_y_q : s1_x_q;
`else
        nan_any = 1'b0;
        nan_sel = 32'h0;
`endif
        res = s1_op_q == 3'd0 ? {31'h0, eq & !nan_any} :
              s1_op_q == 3'd1 ? {31'h0, lt & !nan_any} :
              s1_op_q == 3'd2 ? {31'h0, (lt | eq) & !nan_any} :
              s1_op_q == 3'd3 ? (nan_any ? nan_sel : mn) :
              s1_op_q == 3'd4 ? (nan_any ? nan_sel : mx) : 32'h0;
    end

    always_comb begin
        s2_en    = !s2_v_q | out_ready;
        in_ready = !rst & !flush & (!s1_v_q | !s2_v_q | out_ready);
        acc      = in_valid & in_ready;
        s1_v_d   = flush ? 1'b0 : (!s1_v_q | s2_en) ? acc : s1_v_q;
        s2_v_d   = flush ? 1'b0 : s2_en ? s1_v_q : s2_v_q;
        s1_op_d  = acc ? op : s1_op_q;
        s1_x_d   = acc ? x : s1_x_q;
        s1_y_d   = acc ? y : s1_y_q;
        s1_tag_d = acc ? tag : s1_tag_q;
        s1_xz_d  = acc ? (x[30:23] == 8'h00) : s1_xz_q;
        s1_yz_d  = acc ? (y[30:23] == 8'h00) : s1_yz_q;
`ifdef FCMP_NAN_EN
        s1_xn_d  = acc ? (x[30:23] == 8'hff && x[22:0] != 23'h0) : s1_xn_q;
        s1_yn_d  = acc ? (y[30:23] == 8'hff && y[22:0] != 23'h0) : s1_yn_q;
`endif
        z_d      = (s2_en & s1_v_q) ? res : z_q;
        tag_d    = (s2_en & s1_v_q) ? s1_tag_q : tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_op_q  <= 3'h0;
            s1_x_q   <= 32'h0;
            s1_y_q   <= 32'h0;
            s1_tag_q <= '0;
            s1_xz_q  <= 1'b0;
            s1_yz_q  <= 1'b0;
`ifdef FCMP_NAN_EN
            s1_xn_q  <= 1'b0;
            s1_yn_q  <= 1'b0;
`endif
            z_q      <= 32'h0;
            tag_q    <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            s1_op_q  <= s1_op_d;
            s1_x_q   <= s1_x_d;
            s1_y_q   <= s1_y_d;
            s1_tag_q <= s1_tag_d;
            s1_xz_q  <= s1_xz_d;
            s1_yz_q  <= s1_yz_d;
`ifdef FCMP_NAN_EN
            s1_xn_q  <= s1_xn_d;
            s1_yn_q  <= s1_yn_d;
`endif
            z_q      <= z_d;
            tag_q    <= tag_d;
        end
    end

    assign out_valid = s2_v_q;
    assign z         = z_q;
    assign out_tag   = tag_q;
endmodule

// File: doc/fcmp_unit.md
# fcmp_unit

Pipelined floating-point compare/select unit that drives IEEE-754 single-precision operands through feq/flt/fle/fmin/fmax. It sits between the core's FPU dispatch and writeback. The core side issues requests on a valid/ready handshake; results return on a second valid/ready handshake tagged with the destination register. Fixed 2-cycle latency, one result per cycle at full throughput, lossless under backpressure.

## Interface
Parameters:
- TAG_W, 5, width of destination-register tag carried with each request

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request present
- in_ready  out  1  unit can accept; a transfer occurs when in_valid & in_ready at a rising edge
- op  in  3  000 feq, 001 flt, 010 fle, 011 fmin, 100 fmax, 101–111 reserved
- x, y  in  32  operands (binary32)
- tag  in  TAG_W  destination tag
- flush  in  1  discard all in-flight requests
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts; transfer on out_valid & out_ready
- z  out  32  result: compares give 32'h0/32'h1, min/max give the selected operand bits
- out_tag  out  TAG_W  tag of the result

## Operation
- Two register stages. S1 holds the captured operands/op/tag plus classification: zero (exp==0, subnormals flushed to zero), sign, NaN (exp==255 & mant!=0). S2 holds the final z and tag.
- Ordering: +0 == −0. Subnormals compare equal to zero of the same class. Otherwise sign-magnitude ordering on bits [30:0].
- feq: x==y. flt: x<y. fle: x<y or x==y.
- fmin/fmax return the original 32-bit operand unchanged, never a normalised value. Special cases:
  - −0 vs +0: fmin returns −0, fmax returns +0.
  - Equal values: return x.
- Reserved op: z=32'h0, completes normally.
- Advance rules:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 moves to S2 under the same condition.
  - S1 loads from input when S1 is empty or S1 is moving.
  - in_ready = !rst & !flush & (S1 empty | S2 empty | out_ready).
- Results leave in request order. No reordering, no drops except by flush/rst.
- flush=1: both valid bits clear at that edge. Any input presented in the same cycle is not accepted (in_ready=0). Outputs become invalid the next cycle.
- rst=1: same as flush, and additionally z=0 and out_tag=0.

## Timing
- Reset values: out_valid=0, z=32'h0, out_tag=0. in_ready=0 while rst=1, and 1 in the first cycle after rst deasserts.
- Latency: request accepted at edge N gives out_valid=1 with its z in the cycle after edge N+1 (two edges).
- Throughput: one accept per cycle while out_ready=1. Steady stream has no bubbles.
- Backpressure: while out_valid & !out_ready, z/out_tag/out_valid are held stable. At most 2 requests are held. in_ready drops only when both stages are full and out_ready=0.
- Simultaneous output transfer and input accept with both stages full: allowed in the same cycle, because in_ready includes out_ready.
- Reset or flush mid-operation: in-flight results are never emitted, including one that is valid with out_ready=1 in the flush cycle. That result counts as not transferred.

## Configuration
- FCMP_NAN_EN defined:
  - Any NaN operand makes feq/flt/fle return 0.
  - fmin/fmax with exactly one NaN return the other operand.
  - Both NaN returns canonical 32'h7fc00000.
- Undefined: no NaN detection logic. exp==255 operands are ordered as ordinary magnitudes (infinities and NaNs sort above all finites by bits [30:0]).

## Test plan
- fle x=32'h3f800000, y=32'h40000000, tag=3, out_ready=1 -> two edges later out_valid=1, z=32'h1, out_tag=3. Same operands with flt y,x -> z=0.
- feq x=32'h00000000, y=32'h80000000 -> z=1. fmin on the same pair -> 32'h80000000. fmax -> 32'h00000000. fmin x=32'hbfc00000, y=32'h3f800000 -> 32'hbfc00000.
- Backpressure: 4 back-to-back fmax requests with tags 0–3, out_ready=0 for 3 cycles after first out_valid -> in_ready=0 once 2 are held. Tags then emerge 0,1,2,3 with correct z, and none is lost or duplicated.
- NaN with FCMP_NAN_EN: flt 32'h7fc00000 vs 32'h3f800000 -> 0; fmax 32'h7fc00000 vs 32'h40000000 -> 32'h40000000. Without macro: fmax same -> 32'h7fc00000.
- Flush: accept 2 requests, hold out_ready=0, pulse flush with in_valid=1 -> next cycle out_valid=0, that input not accepted. The next request yields a result after exactly 2 edges.
- Reset mid-stream: assert rst with both stages full -> out_valid=0, z=0, out_tag=0 next cycle, in_ready=0 during rst; reserved op 3'b111 afterwards -> z=0 with its tag.
